video_timing_ctrl: RTL

//  Raster timing generator and pixel scheduler for the display output path.

---
 rtl/video_timing_ctrl_if.sv | 13 +
 rtl/video_timing_ctrl.sv | 73 +++++++
 2 files changed

// File: rtl/video_timing_ctrl_if.sv
// video_timing_ctrl_if: pixel-queue pop port and video output bundle of video_timing_ctrl
interface video_timing_ctrl_if;
    logic       pix_valid;
    logic       pix_rd;
    logic [7:0] pix_y, pix_u, pix_v;
    logic [7:0] y, u, v;
    logic       h_sync, v_sync, pixel_en, frame_start;
    logic [7:0] matrix_coefficients;
    modport master(input pix_valid, pix_y, pix_u, pix_v, output pix_rd,
                   output y, u, v, h_sync, v_sync, pixel_en, frame_start, matrix_coefficients);
    modport slave(output pix_valid, pix_y, pix_u, pix_v, input pix_rd,
                  input y, u, v, h_sync, v_sync, pixel_en, frame_start, matrix_coefficients);
endinterface

// File: rtl/video_timing_ctrl.sv
// video_timing_ctrl: raster timing generator that schedules queued YUV pixels into active video
module video_timing_ctrl #(
    parameter int         CNT_WIDTH = 12,
    parameter logic [7:0] BLACK_Y   = 8'd16,
    parameter logic [7:0] BLACK_C   = 8'd128
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clk_en,
    input  logic [CNT_WIDTH-1:0] h_active, h_fp, h_sync_w, h_bp,
    input  logic [CNT_WIDTH-1:0] v_active, v_fp, v_sync_w, v_bp,
    input  logic [7:0]           matrix_coefficients_in,
    video_timing_ctrl_if.master  bus,
    output logic                 underflow
);
    typedef enum logic [1:0] {SYNC, BP, ACT, FP} phase_t;
    localparam logic [CNT_WIDTH-1:0] ONE = 1;
    phase_t                         h_state, v_state;
    logic [CNT_WIDTH-1:0]           h_cnt, v_cnt, h_len, v_len;
    logic [3:0][CNT_WIDTH-1:0]      sh_h, sh_v, in_h, in_v;
    logic                           fs, active, h_last, v_last, line_end, take;
    assign in_h = {h_fp, h_active, h_bp, h_sync_w};
    assign in_v = {v_fp, v_active, v_bp, v_sync_w};
    assign fs = clk_en && h_state == SYNC && v_state == SYNC && h_cnt == '0 && v_cnt == '0;
    // the frame-start cycle already runs on the freshly loaded timing
    assign h_len = fs ? in_h[h_state] : sh_h[h_state];
    assign v_len = fs ? in_v[v_state] : sh_v[v_state];
    assign h_last = h_len == '0 || h_cnt == h_len - ONE;
    assign v_last = v_len == '0 || v_cnt == v_len - ONE;
    assign line_end = h_state == FP && h_last;
    assign active = h_state == ACT && v_state == ACT;
    assign take = active && bus.pix_valid;
    assign bus.pix_rd = clk_en && take;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_state <= SYNC;
            v_state <= SYNC;
            h_cnt <= '0;
            v_cnt <= '0;
            sh_h <= '0;
            sh_v <= '0;
            bus.y <= BLACK_Y;
            bus.u <= BLACK_C;
            bus.v <= BLACK_C;
            bus.h_sync <= 1'b0;
            bus.v_sync <= 1'b0;
            bus.pixel_en <= 1'b0;
            bus.frame_start <= 1'b0;
            bus.matrix_coefficients <= '0;
            underflow <= 1'b0;
        end else if (clk_en) begin
            if (fs) begin
                sh_h <= in_h;
                sh_v <= in_v;
                bus.matrix_coefficients <= matrix_coefficients_in;
            end
            h_state <= h_last ? phase_t'(h_state + 2'd1) : h_state;
            h_cnt <= h_last ? '0 : h_cnt + ONE;
            if (line_end) begin
                v_state <= v_last ? phase_t'(v_state + 2'd1) : v_state;
                v_cnt <= v_last ? '0 : v_cnt + ONE;
            end
            bus.h_sync <= h_state == SYNC;
            bus.v_sync <= v_state == SYNC;
            bus.pixel_en <= active;
            bus.frame_start <= fs;
            bus.y <= take ? bus.pix_y : BLACK_Y;
            bus.u <= take ? bus.pix_u : BLACK_C;
            bus.v <= take ? bus.pix_v : BLACK_C;
            if (active && !bus.pix_valid) underflow <= 1'b1;
        end
    end
endmodule
